// File: rtl/nv_nvdla_pdp_core_med2d_feed.sv
// Row-pair feeder for the PDP 2D median datapath: buffers the previous row and
// emits vertically aligned (upper, lower) beat pairs with a combined lane mask.
module nv_nvdla_pdp_core_med2d_feed #(
    parameter int LB_DEPTH = 32,
    parameter int LANES    = 8,
    parameter int LANE_W   = 112
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rst,
    input  logic                      op_en,
    input  logic [1:0]                pooling_type,
    input  logic [4:0]                reg2dp_cube_width,
    input  logic [12:0]               reg2dp_cube_height,
    input  logic                      reg2dp_stride_y,
    input  logic                      in_pvld,
    output logic                      in_prdy,
    input  logic [LANES*LANE_W-1:0]   in_pd,
    input  logic [LANES-1:0]          in_mask,
    output logic                      med_pvld,
    input  logic                      med_prdy,
    output logic [LANES*LANE_W-1:0]   med_data0,
    output logic [LANES*LANE_W-1:0]   med_data1,
    output logic [LANES-1:0]          med_data0_valid,
    output logic                      med_last,
    output logic                      busy,
    output logic                      done
);

    localparam int DW = LANES * LANE_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic          start, done_nxt;
    logic [4:0]    w_lat, col;
    logic [12:0]   h_lat, row, final_row;
    logic          stride_lat;
    logic          accept, pair_row, col_end, out_free, lb_we;

    logic [DW-1:0]    lb_pd   [LB_DEPTH];
    logic [LANES-1:0] lb_mask [LB_DEPTH];

    assign out_free  = !med_pvld || med_prdy;
    assign in_prdy   = (state == RUN) && out_free;
    assign accept    = in_pvld && in_prdy;
    assign busy      = (state != IDLE);
    assign col_end   = (col == w_lat);
    assign pair_row  = stride_lat ? row[0] : (row != '0);
    // Stride 2 only keeps even rows as upper rows; stride 1 refreshes every row.
    assign lb_we     = accept && (!stride_lat || !row[0]);
    assign final_row = stride_lat ? (h_lat[0] ? h_lat : h_lat - 13'd1) : h_lat;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (op_en && pooling_type == 2'h3) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                if (accept && col_end && row == h_lat)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_free) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            w_lat      <= '0;
            h_lat      <= '0;
            stride_lat <= 1'b0;
            col        <= '0;
            row        <= '0;
        end else if (start) begin
            w_lat      <= reg2dp_cube_width;
            h_lat      <= reg2dp_cube_height;
            stride_lat <= reg2dp_stride_y;
            col        <= '0;
            row        <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row + 13'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (lb_we)
            lb_pd[col] <= in_pd;
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            for (int unsigned i = 0; i < LB_DEPTH; i++)
                lb_mask[i] <= '0;
        end else if (lb_we) begin
            lb_mask[col] <= in_mask;
        end
    end

    // Output register reads the line buffer before this beat overwrites it.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            med_pvld        <= 1'b0;
            med_last        <= 1'b0;
            med_data0       <= '0;
            med_data1       <= '0;
            med_data0_valid <= '0;
        end else if (accept && pair_row) begin
            med_pvld        <= 1'b1;
            med_last        <= col_end && (row == final_row);
            med_data0       <= lb_pd[col];
            med_data1       <= in_pd;
            med_data0_valid <= lb_mask[col] & in_mask;
        end else if (med_prdy) begin
            med_pvld <= 1'b0;
            med_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nv_nvdla_pdp_core_med2d_feed.sv
// Scoreboard bench for the median row-pair feeder: expected pairs are queued
// as beats are accepted and compared when the pair handshakes out.
module tb_nv_nvdla_pdp_core_med2d_feed;

    localparam int LANES  = 8;
    localparam int LANE_W = 112;
    localparam int DW     = LANES * LANE_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            op_en;
    logic [1:0]      pooling_type;
    logic [4:0]      cube_width;
    logic [12:0]     cube_height;
    logic            stride_y;
    logic            in_pvld;
    logic            in_prdy;
    logic [DW-1:0]   in_pd;
    logic [7:0]      in_mask;
    logic            med_pvld;
    logic            med_prdy;
    logic [DW-1:0]   med_data0;
    logic [DW-1:0]   med_data1;
    logic [7:0]      med_data0_valid;
    logic            med_last;
    logic            busy;
    logic            done;

    nv_nvdla_pdp_core_med2d_feed #(
        .LB_DEPTH(32),
        .LANES(LANES),
        .LANE_W(LANE_W)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .op_en(op_en),
        .pooling_type(pooling_type),
        .reg2dp_cube_width(cube_width),
        .reg2dp_cube_height(cube_height),
        .reg2dp_stride_y(stride_y),
        .in_pvld(in_pvld),
        .in_prdy(in_prdy),
        .in_pd(in_pd),
        .in_mask(in_mask),
        .med_pvld(med_pvld),
        .med_prdy(med_prdy),
        .med_data0(med_data0),
        .med_data1(med_data1),
        .med_data0_valid(med_data0_valid),
        .med_last(med_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [7:0]    v;
        logic          last;
        int            r;
        int            c;
    } pair_t;

    pair_t    sbq[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       last_cyc = 0;
    int       pairs_seen = 0;
    int       mask_mode = 0;
    logic [7:0] salt = 8'h00;
    pair_t    me;

    always @(posedge clk) cyc++;

    // Lane n carries r*16+c in its low bits; lane id and per-cube salt above.
    function automatic logic [DW-1:0] mk_beat(int r, int c);
        logic [DW-1:0] v;
        v = '0;
        for (int n = 0; n < LANES; n++)
            v[n*LANE_W +: LANE_W] = {8'(n + 1), salt, 80'h0, 16'(r * 16 + c)};
        return v;
    endfunction

    function automatic logic [7:0] mask_of(int r);
        if (mask_mode == 0) return 8'hFF;
        return (r % 2 == 1) ? 8'h3C : 8'hF0;
    endfunction

    always @(negedge clk) begin
        if (!rst && med_pvld) begin
            if (sbq.size() == 0) begin
                if (med_prdy) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pair got lane0=%0h want none", med_data1[15:0]);
                end
            end else begin
                me = sbq[0];
                total++;
                if (med_prdy) begin
                    if (med_data0 !== me.d0 || med_data1 !== me.d1 ||
                        med_data0_valid !== me.v || med_last !== me.last) begin
                        bad++;
                        $display("FAIL pair r=%0d c=%0d got d0=%0h d1=%0h v=%h last=%b want d0=%0h d1=%0h v=%h last=%b",
                                 me.r, me.c, med_data0[31:0], med_data1[31:0], med_data0_valid, med_last,
                                 me.d0[31:0], me.d1[31:0], me.v, me.last);
                    end
                    void'(sbq.pop_front());
                    pairs_seen++;
                    if (me.last) last_cyc = cyc;
                end else if (in_prdy !== 1'b0 || med_data0 !== me.d0 || med_data1 !== me.d1) begin
                    bad++;
                    $display("FAIL stall_hold r=%0d c=%0d got in_prdy=%b d1=%0h want in_prdy=0 d1=%0h",
                             me.r, me.c, in_prdy, med_data1[31:0], me.d1[31:0]);
                end
            end
        end
    end

    task automatic start_cube(input int w, input int h, input int s);
        @(posedge clk); #1;
        cube_width   = 5'(w);
        cube_height  = 13'(h);
        stride_y     = s[0];
        pooling_type = 2'h3;
        op_en        = 1'b1;
        pairs_seen   = 0;
        salt         = salt + 8'h11;
        @(posedge clk); #1;
        op_en = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy got=%b want=1", busy);
        end
    endtask

    task automatic send_cube(input int w, input int h, input int s, input int max_beats);
        int    n;
        int    to;
        bit    stop;
        bit    pr;
        pair_t e;
        n = 0;
        stop = 0;
        for (int r = 0; r <= h; r++) begin
            for (int c = 0; c <= w; c++) begin
                if (!stop && (max_beats < 0 || n < max_beats)) begin
                    in_pvld = 1'b1;
                    in_pd   = mk_beat(r, c);
                    in_mask = mask_of(r);
                    to = 0;
                    @(negedge clk);
                    while (!in_prdy && to < 200) begin
                        @(negedge clk);
                        to++;
                    end
                    if (!in_prdy) begin
                        total++;
                        bad++;
                        $display("FAIL in_prdy_timeout r=%0d c=%0d got=0 want=1", r, c);
                        stop = 1;
                    end else begin
                        pr = s ? (r % 2 == 1) : (r > 0);
                        if (pr) begin
                            e.d0   = mk_beat(r - 1, c);
                            e.d1   = mk_beat(r, c);
                            e.v    = mask_of(r - 1) & mask_of(r);
                            e.last = (c == w) && (r == (s ? ((h % 2 == 1) ? h : h - 1) : h));
                            e.r    = r;
                            e.c    = c;
                            sbq.push_back(e);
                        end
                        @(posedge clk); #1;
                        if (pr) begin
                            total++;
                            if (med_pvld !== 1'b1) begin
                                bad++;
                                $display("FAIL pair_latency r=%0d c=%0d got=%b want=1", r, c, med_pvld);
                            end
                        end
                        n++;
                    end
                end
            end
        end
        in_pvld = 1'b0;
    endtask

    task automatic wait_done(input int exp_pairs, input bit gap_chk);
        int to;
        to = 0;
        @(negedge clk);
        while (!done && to < 100) begin
            @(negedge clk);
            to++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done_timeout got=0 want=1");
        end else if (gap_chk) begin
            total++;
            if (cyc - last_cyc != 1) begin
                bad++;
                $display("FAIL done_gap got=%0d want=1", cyc - last_cyc);
            end
        end
        total++;
        if (pairs_seen != exp_pairs || sbq.size() != 0) begin
            bad++;
            $display("FAIL pair_count got=%0d pending=%0d want=%0d", pairs_seen, sbq.size(), exp_pairs);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic check_cleared(input string tag);
        total++;
        if (in_prdy !== 1'b0 || med_pvld !== 1'b0 || med_last !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || med_data0 !== '0 || med_data1 !== '0 || med_data0_valid !== '0) begin
            bad++;
            $display("FAIL %s got prdy=%b pvld=%b last=%b busy=%b done=%b v=%h want all 0",
                     tag, in_prdy, med_pvld, med_last, busy, done, med_data0_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_cleared("reset_release");
    endtask

    task automatic test_stride1();
        mask_mode = 0;
        start_cube(3, 2, 0);
        send_cube(3, 2, 0, -1);
        wait_done(8, 1);
    endtask

    task automatic test_stride2();
        mask_mode = 0;
        start_cube(1, 4, 1);
        send_cube(1, 4, 1, -1);
        wait_done(4, 0);
    endtask

    task automatic test_mask();
        mask_mode = 1;
        start_cube(1, 2, 0);
        send_cube(1, 2, 0, -1);
        wait_done(4, 1);
        mask_mode = 0;
    endtask

    task automatic test_backpressure();
        bit         sdone;
        logic [3:0] pat;
        pat   = 4'b1001;
        sdone = 0;
        start_cube(3, 2, 0);
        fork
            begin
                send_cube(3, 2, 0, -1);
                sdone = 1;
            end
            begin
                int k;
                k = 0;
                while (!sdone) begin
                    med_prdy = pat[k % 4];
                    k++;
                    @(posedge clk); #1;
                end
                med_prdy = 1'b1;
            end
        join
        wait_done(8, 1);
    endtask

    task automatic test_ignore();
        @(posedge clk); #1;
        pooling_type = 2'h1;
        cube_width   = 5'd3;
        cube_height  = 13'd2;
        op_en        = 1'b1;
        @(posedge clk); #1;
        op_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL gated_start got busy=%b want=0", busy);
            end
        end
        start_cube(3, 2, 0);
        fork
            send_cube(3, 2, 0, -1);
            begin
                repeat (3) @(posedge clk);
                #1;
                cube_width   = 5'd1;
                cube_height  = 13'd5;
                pooling_type = 2'h3;
                op_en        = 1'b1;
                @(posedge clk); #1;
                op_en = 1'b0;
            end
        join
        wait_done(8, 1);
    endtask

    task automatic test_async_reset();
        start_cube(3, 2, 0);
        send_cube(3, 2, 0, 9);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("async_reset");
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_cube(3, 2, 0);
        send_cube(3, 2, 0, -1);
        wait_done(8, 1);
    endtask

    initial begin
        rst          = 1'b1;
        op_en        = 1'b0;
        pooling_type = 2'h0;
        cube_width   = '0;
        cube_height  = '0;
        stride_y     = 1'b0;
        in_pvld      = 1'b0;
        in_pd        = '0;
        in_mask      = '0;
        med_prdy     = 1'b1;
        test_reset();
        test_stride1();
        test_stride2();
        test_mask();
        test_backpressure();
        test_ignore();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_pdp_core_med2d_feed.md
# nv_nvdla_pdp_core_med2d_feed

Row-pair feeder for the PDP 2D median datapath. It accepts the pooling input cube as a stream of 8-lane, 112-bit-per-lane beats, one row at a time. It holds the previous row in an internal line buffer and issues vertically aligned row pairs: data0 is the upper row and data1 is the lower row, together with a per-lane valid mask. These pairs drive the median core's data0/data1/data0_valid inputs. It is the transmitting end of that interface and the source of all median-core operands.

## Interface
- LB_DEPTH, 32: line-buffer depth in beats; the maximum row width.
- LANES, 8: lanes per beat.
- LANE_W, 112: bits per lane.
- nvdla_core_clk  in  1  core clock; all state on the rising edge.
- nvdla_core_rst  in  1  asynchronous, active-high reset.
- op_en  in  1  start pulse; sampled only in IDLE.
- pooling_type  in  2  the feeder runs only when this is 2'h3 (median).
- reg2dp_cube_width  in  5  beats per row minus 1 (W).
- reg2dp_cube_height  in  13  rows minus 1 (H).
- reg2dp_stride_y  in  1  0 = vertical stride 1, 1 = stride 2.
- in_pvld  in  1  input beat valid.
- in_prdy  out  1  input beat ready.
- in_pd  in  LANES*LANE_W  input beat; lane n occupies bits [n*112+111 : n*112].
- in_mask  in  LANES  per-lane valid for the beat.
- med_pvld  out  1  pair valid.
- med_prdy  in  1  pair ready.
- med_data0  out  LANES*LANE_W  upper-row beat.
- med_data1  out  LANES*LANE_W  lower-row beat.
- med_data0_valid  out  LANES  per-lane valid for the pair.
- med_last  out  1  marks the final pair of the cube.
- busy  out  1  high when the FSM is not in IDLE.
- done  out  1  single-cycle pulse when the cube is complete.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on op_en with pooling_type==2'h3.
  - W, H and stride are latched at this point; col and row are cleared.
  - op_en with any other pooling_type is ignored.
  - op_en in RUN or DRAIN is ignored.
- Input acceptance: a beat is accepted when in_pvld & in_prdy.
  - in_prdy = (state==RUN) & (!med_pvld | med_prdy).
- Row classification:
  - Stride 1: row 0 is store-only; rows 1..H are pair rows.
  - Stride 2: even rows are store-only; odd rows are pair rows.
- Store-only beat: LB[col] <= {in_mask, in_pd}. No output is produced.
- Pair-row beat: the output register loads
  - med_data0 = LB[col].pd
  - med_data1 = in_pd
  - med_data0_valid = LB[col].mask & in_mask
  - med_pvld is set.
  - In stride 1, LB[col] is also overwritten with the current beat.
- Counters:
  - col increments on each accepted beat and wraps to 0 after W.
  - row increments on that wrap.
- End of cube: acceptance of beat (col==W, row==H) moves the FSM to DRAIN.
- med_last is set with the pair produced at col==W of the final pair row.
  - Final pair row is H for stride 1.
  - For stride 2 it is H if H is odd, otherwise H-1.
  - For stride 2 with H even, the last row is store-only and is discarded.
  - H==0 produces no pairs at all.
- DRAIN: when the output register is empty, or is emptied this cycle by a med_prdy handshake, the block pulses done and returns to IDLE.
- Output register: holds its value while med_pvld & !med_prdy. It clears med_pvld on handshake unless a new pair loads in the same cycle.

## Timing
- Reset values:
  - FSM is IDLE.
  - in_prdy, med_pvld, med_last, busy and done are 0.
  - med_data0, med_data1 and med_data0_valid are 0.
  - All line-buffer mask bits are 0; the line-buffer data is not reset.
- Latency: a pair is visible on med_pvld one cycle after the lower-row beat is accepted.
- Throughput: one beat per cycle when med_prdy is held high.
- Backpressure: med_prdy low with med_pvld high forces in_prdy low in the same cycle, with no beat loss.
  - Store-only rows also stall under this condition; this is accepted for simplicity.
- done asserts the cycle after the final pair handshake. For H==0, it asserts the cycle after the last beat is accepted.
- Reset mid-operation returns the block to IDLE immediately, discards any partial pair and clears the masks. The next op_en starts a clean cube.

## Test plan
- Stride 1, W=3, H=2, lane n of row r beat c = r*16+c, mask 8'hFF, med_prdy=1:
  - Expect 8 pairs.
  - Pair (r=1, c=2) has data0 lane = 2 and data1 lane = 18.
  - med_last only on (r=2, c=3).
  - done 1 cycle after the final pair.
- Stride 2, W=1, H=4:
  - Pairs come only from rows 1 and 3, for 4 pairs total.
  - med_last on (r=3, c=1).
  - Row 4 is consumed with no output, then done.
- Masking: upper-row mask 8'hF0 and lower-row mask 8'h3C -> med_data0_valid = 8'h30.
- Backpressure: med_prdy toggles 1,0,0,1 during a pair row.
  - in_prdy drops while stalled.
  - The held pair stays stable.
  - No pairs are dropped or duplicated; the pair count still matches the first scenario.
- Gating and ignores:
  - op_en with pooling_type=2'h1 -> busy stays 0.
  - op_en during RUN -> latched W and H are unchanged.
- Asynchronous reset asserted mid-row-2 of the first scenario:
  - Outputs clear immediately.
  - A restarted cube produces the full 8 correct pairs.
